two_level_bht: RTL and testbench

TWO_LEVEL_BHT -- requirements
Module: two_level_bht

---
 rtl/bp_two_level_pkg.sv | 35 +++
 rtl/two_level_bht_sat_ctr.sv | 27 ++
 rtl/two_level_bht.sv | 150 +++++++++++++++
 tb/tb_two_level_bht.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bp_two_level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_two_level_pkg
// Description : Shared types and helpers for the two-level branch history
//               table: FSM state encoding, counter reset value and index-width
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_two_level_pkg;

  // Two-state controller: sweep-initialise the tables, then serve requests.
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } bht_state_e;

  // PC bit where the table indices start (instruction alignment).
  localparam int c_pc_lsb = 2;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int ctr_reset_val(input int ctr_width);
    return (1 << (ctr_width - 1)) - 1;
  endfunction

  // PHT index = {PC bits, local history}.
  function automatic int pht_idx_width(input int pc_bits, input int hist_width);
    return pc_bits + hist_width;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/two_level_bht_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : two_level_bht_sat_ctr
// Description : Next-state logic of an up/down saturating counter. Counts up
//               on taken, down on not-taken, holding at all-ones and zero.
// Revision    : 1.0 - initial release
// ============================================================================
module two_level_bht_sat_ctr #(
  parameter int ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] count_i,
  input  logic                   taken_i,
  output logic [ctr_width_p-1:0] next_count_o
);

  // Step toward the observed outcome unless already pinned at that end.
  always_comb begin
    next_count_o = count_i;
    if (taken_i && (count_i != '1)) begin
      next_count_o = count_i + 1'b1;
    end else if (!taken_i && (count_i != '0)) begin
      next_count_o = count_i - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/two_level_bht.sv
`default_nettype none
// ============================================================================
// Module      : two_level_bht
// Description : Two-level local-history branch predictor. A PC-indexed BHT of
//               local histories selects, together with low PC bits, a
//               saturating counter in the PHT. One-cycle read latency, one
//               update per cycle, self-initialising after reset.
//               Macro TWO_LEVEL_BHT_BYPASS_EN: when defined, a read colliding
//               with a same-cycle update returns the post-update history and
//               counter; otherwise it returns the pre-update values.
// Revision    : 1.0 - initial release
// ============================================================================
module two_level_bht
  import bp_two_level_pkg::*;
#(
  parameter int pc_width_p    = 39,
  parameter int bht_els_p     = 16,
  parameter int hist_width_p  = 4,
  parameter int pht_pc_bits_p = 2,
  parameter int ctr_width_p   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  output logic                    ready_o,
  input  logic                    r_v_i,
  input  logic [pc_width_p-1:0]   r_pc_i,
  output logic                    r_v_o,
  output logic                    r_taken_o,
  output logic [hist_width_p-1:0] r_hist_o,
  input  logic                    w_v_i,
  input  logic [pc_width_p-1:0]   w_pc_i,
  input  logic                    w_taken_i,
  input  logic [hist_width_p-1:0] w_hist_i
);

  localparam int c_bht_idx_w  = $clog2(bht_els_p);
  localparam int c_pht_idx_w  = pht_idx_width(pht_pc_bits_p, hist_width_p);
  localparam int c_pht_els    = 1 << c_pht_idx_w;
  localparam int c_init_cnt   = max_int(bht_els_p, c_pht_els);
  localparam int c_init_idx_w = $clog2(c_init_cnt);

  localparam logic [c_init_idx_w-1:0] c_init_last = c_init_idx_w'(c_init_cnt - 1);
  localparam logic [c_init_idx_w-1:0] c_bht_last  = c_init_idx_w'(bht_els_p - 1);
  localparam logic [c_init_idx_w-1:0] c_pht_last  = c_init_idx_w'(c_pht_els - 1);
  localparam logic [ctr_width_p-1:0]  c_ctr_init  = ctr_width_p'(ctr_reset_val(ctr_width_p));

  bht_state_e                r_state;
  logic [c_init_idx_w-1:0]   r_init_idx;
  logic [hist_width_p-1:0]   r_bht [bht_els_p];
  logic [ctr_width_p-1:0]    r_pht [c_pht_els];

  logic                      w_rd_acc;
  logic                      w_wr_acc;
  logic [c_bht_idx_w-1:0]    w_rd_bht_idx;
  logic [c_bht_idx_w-1:0]    w_wr_bht_idx;
  logic [hist_width_p-1:0]   w_wr_bht_old;
  logic [hist_width_p-1:0]   w_wr_bht_new;
  logic [c_pht_idx_w-1:0]    w_wr_pht_idx;
  logic [c_pht_idx_w-1:0]    w_rd_pht_idx;
  logic [ctr_width_p-1:0]    w_ctr_next;
  logic [hist_width_p-1:0]   w_rd_hist;
  logic [ctr_width_p-1:0]    w_rd_ctr;
  logic                      w_unused_bits;

  assign ready_o  = (r_state == READY);
  assign w_rd_acc = r_v_i & ready_o;
  assign w_wr_acc = w_v_i & ready_o;

  assign w_rd_bht_idx = r_pc_i[c_pc_lsb +: c_bht_idx_w];
  assign w_wr_bht_idx = w_pc_i[c_pc_lsb +: c_bht_idx_w];

  // The new history shifts the stored entry; the PHT is indexed by the
  // history the predictor actually used, which the caller hands back.
  assign w_wr_bht_old = r_bht[w_wr_bht_idx];
  assign w_wr_bht_new = {w_wr_bht_old[hist_width_p-2:0], w_taken_i};
  assign w_wr_pht_idx = {w_pc_i[c_pc_lsb +: pht_pc_bits_p], w_hist_i};

  two_level_bht_sat_ctr #(
    .ctr_width_p (ctr_width_p)
  ) u_sat_ctr (
    .count_i      (r_pht[w_wr_pht_idx]),
    .taken_i      (w_taken_i),
    .next_count_o (w_ctr_next)
  );

`ifdef TWO_LEVEL_BHT_BYPASS_EN
  // Forward the in-flight update into a colliding read.
  assign w_rd_hist    = (w_wr_acc && (w_wr_bht_idx == w_rd_bht_idx))
                        ? w_wr_bht_new : r_bht[w_rd_bht_idx];
  assign w_rd_pht_idx = {r_pc_i[c_pc_lsb +: pht_pc_bits_p], w_rd_hist};
  assign w_rd_ctr     = (w_wr_acc && (w_wr_pht_idx == w_rd_pht_idx))
                        ? w_ctr_next : r_pht[w_rd_pht_idx];
`else
  // Reads see the table contents as they stood before this cycle's update.
  assign w_rd_hist    = r_bht[w_rd_bht_idx];
  assign w_rd_pht_idx = {r_pc_i[c_pc_lsb +: pht_pc_bits_p], w_rd_hist};
  assign w_rd_ctr     = r_pht[w_rd_pht_idx];
`endif

  // PC bits outside the index fields and the history bit shifted out.
  assign w_unused_bits = ^{r_pc_i, w_pc_i, w_wr_bht_old[hist_width_p-1]};

  // Controller: init sweep counter, state, and the registered read response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= INIT;
      r_init_idx <= '0;
      r_v_o      <= 1'b0;
      r_taken_o  <= 1'b0;
      r_hist_o   <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_init_idx == c_init_last) begin
            r_state <= READY;
          end else begin
            r_init_idx <= r_init_idx + 1'b1;
          end
        end
        READY:   r_state <= READY;
        default: r_state <= INIT;
      endcase
      r_v_o <= w_rd_acc;
      if (w_rd_acc) begin
        r_hist_o  <= w_rd_hist;
        r_taken_o <= w_rd_ctr[ctr_width_p-1];
      end
    end
  end

  // Table writes: one entry of each table per cycle while initialising,
  // otherwise the accepted update.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (r_state == INIT) begin
        if (r_init_idx <= c_bht_last) begin
          r_bht[r_init_idx[c_bht_idx_w-1:0]] <= '0;
        end
        if (r_init_idx <= c_pht_last) begin
          r_pht[r_init_idx[c_pht_idx_w-1:0]] <= c_ctr_init;
        end
      end else if (w_wr_acc) begin
        r_bht[w_wr_bht_idx] <= w_wr_bht_new;
        r_pht[w_wr_pht_idx] <= w_ctr_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_two_level_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_level_bht
// Description : Directed self-checking bench for two_level_bht at default
//               parameters. Honours TWO_LEVEL_BHT_BYPASS_EN for collision
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_two_level_bht;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ready_o;
  logic        r_v_i;
  logic [38:0] r_pc_i;
  logic        r_v_o;
  logic        r_taken_o;
  logic [3:0]  r_hist_o;
  logic        w_v_i;
  logic [38:0] w_pc_i;
  logic        w_taken_i;
  logic [3:0]  w_hist_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  two_level_bht dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ready_o   (ready_o),
    .r_v_i     (r_v_i),
    .r_pc_i    (r_pc_i),
    .r_v_o     (r_v_o),
    .r_taken_o (r_taken_o),
    .r_hist_o  (r_hist_o),
    .w_v_i     (w_v_i),
    .w_pc_i    (w_pc_i),
    .w_taken_i (w_taken_i),
    .w_hist_i  (w_hist_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One read; response must appear exactly one cycle later and only then.
  task automatic rd(input string tag, input logic [38:0] pc,
                    input logic [3:0] exp_hist, input logic exp_taken);
    r_v_i  = 1'b1;
    r_pc_i = pc;
    tick();
    r_v_i = 1'b0;
    check({tag, "_rv"},    {31'd0, r_v_o},     32'd1);
    check({tag, "_hist"},  {28'd0, r_hist_o},  {28'd0, exp_hist});
    check({tag, "_taken"}, {31'd0, r_taken_o}, {31'd0, exp_taken});
    tick();
    check({tag, "_rv_drop"}, {31'd0, r_v_o}, 32'd0);
  endtask

  task automatic upd(input logic [38:0] pc, input logic taken, input logic [3:0] hist);
    w_v_i     = 1'b1;
    w_pc_i    = pc;
    w_taken_i = taken;
    w_hist_i  = hist;
    tick();
    w_v_i = 1'b0;
  endtask

  // Count edges until ready_o rises; optionally verify no response meanwhile.
  task automatic wait_ready(input string tag, input bit quiet_chk);
    int cycles = 0;
    while (ready_o !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
      if (quiet_chk) check({tag, "_no_rv"}, {31'd0, r_v_o}, 32'd0);
    end
    r_v_i = 1'b0;
    w_v_i = 1'b0;
    check({tag, "_len"}, cycles, 32'd64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    r_v_i = 1'b0; r_pc_i = '0;
    w_v_i = 1'b0; w_pc_i = '0; w_taken_i = 1'b0; w_hist_i = '0;
    tick();
    tick();
    check("rst_ready", {31'd0, ready_o},   32'd0);
    check("rst_rv",    {31'd0, r_v_o},     32'd0);
    check("rst_taken", {31'd0, r_taken_o}, 32'd0);
    check("rst_hist",  {28'd0, r_hist_o},  32'd0);
    reset_i = 1'b0;
    wait_ready("init", 1'b0);

    rd("first_40", 39'h40, 4'b0000, 1'b0);
    rd("first_7c", 39'h7c, 4'b0000, 1'b0);

    // History build on PC 0x40, feeding back the history just read.
    upd(39'h40, 1'b1, 4'b0000);
    rd("hist1", 39'h40, 4'b0001, 1'b0);
    upd(39'h40, 1'b1, 4'b0001);
    rd("hist2", 39'h40, 4'b0011, 1'b0);
    upd(39'h40, 1'b1, 4'b0011);                 // ctr{00,0011} -> 2
    rd("hist3", 39'h40, 4'b0111, 1'b0);

    // PC 0x60 (BHT 8, PC bits 00) given history 0011 to observe ctr{00,0011}.
    upd(39'h60, 1'b1, 4'b1000);
    upd(39'h60, 1'b1, 4'b1001);
    rd("ctr2", 39'h60, 4'b0011, 1'b1);
    upd(39'h50, 1'b1, 4'b0011);                 // -> 3
    upd(39'h50, 1'b1, 4'b0011);                 // saturates at 3
    rd("ctr_sat", 39'h60, 4'b0011, 1'b1);
    upd(39'h50, 1'b0, 4'b0011);                 // -> 2
    rd("dec2", 39'h60, 4'b0011, 1'b1);
    upd(39'h50, 1'b0, 4'b0011);                 // -> 1
    rd("dec1", 39'h60, 4'b0011, 1'b0);
    upd(39'h50, 1'b0, 4'b0011);                 // -> 0
    rd("dec0", 39'h60, 4'b0011, 1'b0);
    upd(39'h50, 1'b0, 4'b0011);                 // stays 0
    rd("dec_floor", 39'h60, 4'b0011, 1'b0);
    upd(39'h50, 1'b1, 4'b0011);                 // -> 1
    upd(39'h50, 1'b1, 4'b0011);                 // -> 2
    rd("reinc", 39'h60, 4'b0011, 1'b1);

    // Reset pulse with a read in flight; requests held during INIT.
    r_v_i = 1'b1; r_pc_i = 39'h40;
    w_v_i = 1'b1; w_pc_i = 39'h40; w_taken_i = 1'b1; w_hist_i = 4'b0000;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rst2_rv",    {31'd0, r_v_o},     32'd0);
    check("rst2_ready", {31'd0, ready_o},   32'd0);
    check("rst2_hist",  {28'd0, r_hist_o},  32'd0);
    check("rst2_taken", {31'd0, r_taken_o}, 32'd0);
    wait_ready("reinit", 1'b1);
    rd("reinit_40", 39'h40, 4'b0000, 1'b0);
    rd("reinit_60", 39'h60, 4'b0011 & 4'b0000, 1'b0);

    // BHT collision: history 0001 at PC 0x40, read+update taken same cycle.
    upd(39'h40, 1'b1, 4'b0000);
    r_v_i = 1'b1; r_pc_i = 39'h40;
    w_v_i = 1'b1; w_pc_i = 39'h40; w_taken_i = 1'b1; w_hist_i = 4'b0001;
    tick();
    r_v_i = 1'b0; w_v_i = 1'b0;
    check("coll_bht_rv", {31'd0, r_v_o}, 32'd1);
`ifdef TWO_LEVEL_BHT_BYPASS_EN
    check("coll_bht_hist", {28'd0, r_hist_o}, 32'b0011);
`else
    check("coll_bht_hist", {28'd0, r_hist_o}, 32'b0001);
`endif
    check("coll_bht_taken", {31'd0, r_taken_o}, 32'd0);
    tick();
    rd("after_coll", 39'h40, 4'b0011, 1'b0);

    // PHT collision: read PC 0x40 (hist 0011) while PC 0x50 bumps ctr{00,0011}.
    r_v_i = 1'b1; r_pc_i = 39'h40;
    w_v_i = 1'b1; w_pc_i = 39'h50; w_taken_i = 1'b1; w_hist_i = 4'b0011;
    tick();
    r_v_i = 1'b0; w_v_i = 1'b0;
    check("coll_pht_hist", {28'd0, r_hist_o}, 32'b0011);
`ifdef TWO_LEVEL_BHT_BYPASS_EN
    check("coll_pht_taken", {31'd0, r_taken_o}, 32'd1);
`else
    check("coll_pht_taken", {31'd0, r_taken_o}, 32'd0);
`endif
    tick();
    rd("after_pht", 39'h40, 4'b0011, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
